// File: rtl/popcount_csa_seq.sv
// Sequential multi-word population counter.
// Each accepted word is reduced C bits per cycle into a carry-save (S, K)
// accumulator; one ripple-carry resolve cycle produces the packet count.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_ACCEPT   | idle, in_rdy=1, waiting for the next word of a packet
// ST_REDUCE   | compressing one C-bit chunk per cycle into S/K (W/C cycles)
// ST_RESOLVE  | single cycle: out_cnt <= S + (K << 1) through a ripple chain
// ST_OUT      | out_vld=1, result held until out_rdy
module popcount_csa_seq #(
    parameter  int W     = 32,
    parameter  int C     = 8,
    parameter  int N_MAX = 16,
    localparam int OW    = $clog2(W * N_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_dat,
    input  logic          in_last,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [OW-1:0] out_cnt,
    output logic          out_ovf
);

    localparam int NCH  = W / C;
    localparam int PW   = $clog2(C + 1);
    localparam int CIW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WCW  = $clog2(N_MAX + 2);
    localparam int NTRI = C / 3;

    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_REDUCE  = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    sh_q;
    logic            last_q;
    logic [CIW-1:0]  cidx_q;
    logic [WCW-1:0]  wcnt_q;
    logic            ovf_q;
    logic [OW-1:0]   s_q;
    logic [OW-1:0]   k_q;

    logic [C-1:0]    chunk;
    logic [PW-1:0]   part_cnt;
    logic [1:0]      tri_r;
    logic [OW-1:0]   part_ext;
    logic [OW-1:0]   k_sh;
    logic [OW-1:0]   s_nx;
    logic [OW-1:0]   k_nx;
    logic [1:0]      csa_r;
    logic [OW-1:0]   res_sum;

    logic            last_chunk;
    logic            accept;
    logic            release_res;

    // One full adder: returns {carry, sum}.
    function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
        fa = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

    // PW-bit ripple-carry adder built from full adders; final carry dropped.
    function automatic logic [PW-1:0] add_pw(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] s;
        logic [1:0]    r;
        logic          c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < PW; i++) begin
            r    = fa(a[i], b[i], c);
            s[i] = r[0];
            c    = r[1];
        end
        return s;
    endfunction

    // OW-bit ripple-carry adder used only in the resolve cycle; wraps mod 2^OW.
    function automatic logic [OW-1:0] add_ow(input logic [OW-1:0] a, input logic [OW-1:0] b);
        logic [OW-1:0] s;
        logic [1:0]    r;
        logic          c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < OW; i++) begin
            r    = fa(a[i], b[i], c);
            s[i] = r[0];
            c    = r[1];
        end
        return s;
    endfunction

    assign chunk       = sh_q[C-1:0];
    assign last_chunk  = (cidx_q == CIW'(NCH - 1));
    assign in_rdy      = (state_q == ST_ACCEPT);
    assign out_vld     = (state_q == ST_OUT);
    assign accept      = in_vld & in_rdy;
    assign release_res = out_vld & out_rdy;

    // Chunk popcount: bit triples go through full adders, then fold into the count.
    always_comb begin
        part_cnt = '0;
        tri_r    = '0;
        for (int i = 0; i < NTRI; i++) begin
            tri_r    = fa(chunk[3*i], chunk[3*i+1], chunk[3*i+2]);
            part_cnt = add_pw(part_cnt, PW'(tri_r));
        end
        for (int i = 3 * NTRI; i < C; i++) begin
            part_cnt = add_pw(part_cnt, PW'(chunk[i]));
        end
    end

    // 3:2 compressor row: {S, K<<1, partial} -> new {S, K}, no carry ripple.
    always_comb begin
        k_sh     = k_q << 1;
        part_ext = OW'(part_cnt);
        s_nx     = '0;
        k_nx     = '0;
        csa_r    = '0;
        for (int i = 0; i < OW; i++) begin
            csa_r   = fa(s_q[i], k_sh[i], part_ext[i]);
            s_nx[i] = csa_r[0];
            k_nx[i] = csa_r[1];
        end
    end

    // Carry-save resolve for the RESOLVE cycle.
    always_comb begin
        res_sum = add_ow(s_q, k_sh);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: begin
                if (in_vld) begin
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (last_chunk) begin
                    state_d = last_q ? ST_RESOLVE : ST_ACCEPT;
                end
            end
            ST_RESOLVE: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_rdy) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // Word capture, per-chunk accumulation, result register and packet clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q    <= '0;
            last_q  <= 1'b0;
            cidx_q  <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            s_q     <= '0;
            k_q     <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else begin
            if (accept) begin
                sh_q   <= in_dat;
                last_q <= in_last;
                cidx_q <= '0;
                // Counter parks at N_MAX+1 so a long packet cannot wrap it back.
                if (wcnt_q != WCW'(N_MAX + 1)) begin
                    wcnt_q <= wcnt_q + WCW'(1);
                end
                if (wcnt_q == WCW'(N_MAX)) begin
                    ovf_q <= 1'b1;
                end
            end
            if (state_q == ST_REDUCE) begin
                s_q  <= s_nx;
                k_q  <= k_nx;
                sh_q <= sh_q >> C;
                if (!last_chunk) begin
                    cidx_q <= cidx_q + CIW'(1);
                end
            end
            if (state_q == ST_RESOLVE) begin
                out_cnt <= res_sum;
                out_ovf <= ovf_q;
            end
            if (release_res) begin
                s_q    <= '0;
                k_q    <= '0;
                wcnt_q <= '0;
                ovf_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_popcount_csa_seq.sv
// Bench for popcount_csa_seq: three instances (C = 1, 8, 32) run the same
// directed packets plus random packets against a countones-based model.
module tb_popcount_csa_seq;

    localparam int W     = 32;
    localparam int N_MAX = 16;
    localparam int OW    = $clog2(W * N_MAX + 1);

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_u
        localparam int CV      = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
        localparam int NCH     = W / CV;
        localparam int RST_CYC = (NCH > 1) ? 2 : 1;

        logic          rst;
        logic          in_vld;
        logic          in_rdy;
        logic [W-1:0]  in_dat;
        logic          in_last;
        logic          out_vld;
        logic          out_rdy;
        logic [OW-1:0] out_cnt;
        logic          out_ovf;
        bit            done = 1'b0;

        popcount_csa_seq #(.W(W), .C(CV), .N_MAX(N_MAX)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .in_vld  (in_vld),
            .in_rdy  (in_rdy),
            .in_dat  (in_dat),
            .in_last (in_last),
            .out_vld (out_vld),
            .out_rdy (out_rdy),
            .out_cnt (out_cnt),
            .out_ovf (out_ovf)
        );

        // Called and returns at a falling edge.
        task automatic put_word(input logic [W-1:0] d, input logic l);
            int n = 0;
            while (in_rdy !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("c%0d_rdy_wait", CV), {31'b0, in_rdy}, 1);
            in_vld  = 1'b1;
            in_dat  = d;
            in_last = l;
            @(negedge clk);
            // REDUCE cycles: in_rdy must stay low; junk on the inputs must be ignored.
            for (int k = 1; k <= NCH; k++) begin
                chk($sformatf("c%0d_rdy_low", CV), {31'b0, in_rdy}, 0);
                in_vld  = (k < NCH) ? 1'($urandom) : 1'b0;
                in_dat  = $urandom;
                in_last = 1'($urandom);
                @(negedge clk);
            end
            in_vld = 1'b0;
            if (l) begin
                chk($sformatf("c%0d_resolve_vld", CV), {31'b0, out_vld}, 0);
                chk($sformatf("c%0d_resolve_rdy", CV), {31'b0, in_rdy}, 0);
                @(negedge clk);
                chk($sformatf("c%0d_latency_vld", CV), {31'b0, out_vld}, 1);
            end else begin
                chk($sformatf("c%0d_rdy_back", CV), {31'b0, in_rdy}, 1);
            end
        endtask

        task automatic get_result(input int exp_cnt, input logic exp_ovf, input int hold);
            for (int h = 0; h < hold; h++) begin
                chk($sformatf("c%0d_hold_vld", CV), {31'b0, out_vld}, 1);
                chk($sformatf("c%0d_hold_cnt", CV), 32'(out_cnt), exp_cnt);
                chk($sformatf("c%0d_hold_rdy", CV), {31'b0, in_rdy}, 0);
                @(negedge clk);
            end
            chk($sformatf("c%0d_cnt", CV), 32'(out_cnt), exp_cnt);
            chk($sformatf("c%0d_ovf", CV), {31'b0, out_ovf}, {31'b0, exp_ovf});
            chk($sformatf("c%0d_out_vld", CV), {31'b0, out_vld}, 1);
            out_rdy = 1'b1;
            @(negedge clk);
            out_rdy = 1'b0;
            chk($sformatf("c%0d_xfer_vld", CV), {31'b0, out_vld}, 0);
            chk($sformatf("c%0d_xfer_rdy", CV), {31'b0, in_rdy}, 1);
        endtask

        // Reference: packet count is the sum of per-word countones, wrapped to OW bits.
        task automatic send_packet(input logic [W-1:0] w[$], input int hold, input int max_gap);
            int sum = 0;
            foreach (w[i]) sum += $countones(w[i]);
            for (int i = 0; i < w.size(); i++) begin
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
                put_word(w[i], (i == w.size() - 1));
            end
            get_result(sum % (1 << OW), (w.size() > N_MAX), hold);
        endtask

        initial begin
            logic [W-1:0] q[$];
            int           nw;
            rst     = 1'b0;
            in_vld  = 1'b0;
            in_dat  = '0;
            in_last = 1'b0;
            out_rdy = 1'b0;
            repeat (2) @(negedge clk);
            chk($sformatf("c%0d_rst_rdy", CV), {31'b0, in_rdy}, 1);
            chk($sformatf("c%0d_rst_vld", CV), {31'b0, out_vld}, 0);
            chk($sformatf("c%0d_rst_cnt", CV), 32'(out_cnt), 0);
            chk($sformatf("c%0d_rst_ovf", CV), {31'b0, out_ovf}, 0);
            rst = 1'b1;
            @(negedge clk);

            q = {32'hFFFF_FFFF};
            send_packet(q, 0, 0);
            q = {32'h0000_0000, 32'h0000_0001, 32'h8000_0001};
            send_packet(q, 0, 0);
            q = {32'h0001_FFFF};
            send_packet(q, 10, 0);
            q = {32'h0000_0003};
            send_packet(q, 0, 0);

            q = {};
            repeat (N_MAX) q.push_back(32'hFFFF_FFFF);
            send_packet(q, 0, 0);
            q.push_back(32'hFFFF_FFFF);
            send_packet(q, 0, 0);
            q = {32'h0000_0001};
            send_packet(q, 0, 0);

            // Reset in the middle of REDUCE discards the packet.
            chk($sformatf("c%0d_pre_rst_rdy", CV), {31'b0, in_rdy}, 1);
            in_vld  = 1'b1;
            in_dat  = 32'hFFFF_FFFF;
            in_last = 1'b1;
            @(negedge clk);
            in_vld = 1'b0;
            repeat (RST_CYC - 1) @(negedge clk);
            rst = 1'b0;
            #1;
            chk($sformatf("c%0d_mid_rst_vld", CV), {31'b0, out_vld}, 0);
            chk($sformatf("c%0d_mid_rst_rdy", CV), {31'b0, in_rdy}, 1);
            chk($sformatf("c%0d_mid_rst_cnt", CV), 32'(out_cnt), 0);
            @(negedge clk);
            chk($sformatf("c%0d_in_rst_rdy", CV), {31'b0, in_rdy}, 1);
            rst = 1'b1;
            @(negedge clk);
            q = {32'h0000_000F};
            send_packet(q, 0, 0);

            repeat (10) begin
                q  = {};
                nw = $urandom_range(1, N_MAX);
                repeat (nw) q.push_back($urandom);
                send_packet(q, $urandom_range(0, 3), 2);
            end
            done = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(g_u[0].done && g_u[1].done && g_u[2].done) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("all_done", {31'b0, g_u[0].done & g_u[1].done & g_u[2].done}, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
